// File: rtl/plugin_recurrence_gen_if.sv
// Start/busy/done plugin handshake bundle for plugin_recurrence_gen.
// The master drives the request fields and the slave returns status and result.
interface plugin_recurrence_gen_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             overflow;

    modport master (
        output start, mode, operand_a, operand_b,
        input  busy, done, result, overflow
    );

    modport slave (
        input  start, mode, operand_a, operand_b,
        output busy, done, result, overflow
    );
endinterface

// File: rtl/plugin_recurrence_gen.sv
// Iterative n-th term generator for the Fibonacci, Lucas, Pell and Tribonacci recurrences.
// Defining PLUGIN_REC_MODULO_EN adds reduction of every term modulo operand_b.
module plugin_recurrence_gen #(
    parameter int WIDTH = 32,
    parameter int MAX_N = 1023
) (
    input  logic                   clk,
    input  logic                   reset,
    plugin_recurrence_gen_if.slave bus
);
    localparam int CW = $clog2(MAX_N + 1);

    typedef enum logic [1:0] {IDLE, LOAD, CALC, FINISH} state_e;
    typedef enum logic [1:0] {MODE_FIB, MODE_LUCAS, MODE_PELL, MODE_TRIB} mode_e;

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] t0_q, t0_d;  // a(i-1), the newest term
    logic [WIDTH-1:0] t1_q, t1_d;  // a(i-2)
    logic [WIDTH-1:0] t2_q, t2_d;  // a(i-3), Tribonacci only
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             overflow_q, overflow_d;
    logic             arith_ovf_en;

`ifdef PLUGIN_REC_MODULO_EN
    logic [WIDTH-1:0] mod_q, mod_d;

    // Inputs never exceed 3m, so two conditional subtractions complete the reduction.
    function automatic logic [WIDTH-1:0] fold(input logic [WIDTH+1:0] v);
        logic [WIDTH+1:0] m;
        logic [WIDTH+1:0] r;
        m = {2'b00, mod_q};
        r = v;
        if (m != '0) begin
            if (r >= m) r = r - m;
            if (r >= m) r = r - m;
        end
        return r[WIDTH-1:0];
    endfunction

    assign arith_ovf_en = (mod_q == '0);
`else
    logic unused_operand_b;

    function automatic logic [WIDTH-1:0] fold(input logic [WIDTH+1:0] v);
        return v[WIDTH-1:0];
    endfunction

    assign arith_ovf_en     = 1'b1;
    assign unused_operand_b = ^bus.operand_b;
`endif

    logic             k3;
    logic [WIDTH-1:0] k_val;
    logic             short_n;
    logic [WIDTH-1:0] s0, s1, s2;
    logic [WIDTH-1:0] seed_at_n;
    logic [WIDTH+1:0] step;

    assign k3      = (mode_q == MODE_TRIB);
    assign k_val   = k3 ? WIDTH'(3) : WIDTH'(2);
    assign short_n = (n_q < k_val);

    always_comb begin
        s0 = fold((mode_q == MODE_LUCAS) ? (WIDTH+2)'(2) : '0);
        s1 = fold(k3 ? '0 : (WIDTH+2)'(1));
        s2 = fold(k3 ? (WIDTH+2)'(1) : '0);
        unique case (n_q[1:0])
            2'd0:    seed_at_n = s0;
            2'd1:    seed_at_n = s1;
            default: seed_at_n = s2;
        endcase
    end

    always_comb begin
        unique case (mode_q)
            MODE_PELL: step = {1'b0, t0_q, 1'b0} + {2'b00, t1_q};
            MODE_TRIB: step = {2'b00, t0_q} + {2'b00, t1_q} + {2'b00, t2_q};
            default:   step = {2'b00, t0_q} + {2'b00, t1_q};
        endcase
    end

    // NOTE: every signal gets a hold default first, so no path through this block infers a latch.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        n_d        = n_q;
        t0_d       = t0_q;
        t1_d       = t1_q;
        t2_d       = t2_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        overflow_d = overflow_q;
`ifdef PLUGIN_REC_MODULO_EN
        mod_d      = mod_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    n_d     = bus.operand_a;
                    mode_d  = mode_e'(bus.mode);
`ifdef PLUGIN_REC_MODULO_EN
                    mod_d   = bus.operand_b;
`endif
                    state_d = LOAD;
                end
            end
            LOAD: begin
                t0_d       = k3 ? s2 : s1;
                t1_d       = k3 ? s1 : s0;
                t2_d       = k3 ? s0 : '0;
                overflow_d = 1'b0;
                if (n_q > WIDTH'(MAX_N)) begin
                    result_d   = '0;
                    overflow_d = 1'b1;
                    state_d    = FINISH;
                end else if (short_n) begin
                    result_d = seed_at_n;
                    state_d  = FINISH;
                end else begin
                    cnt_d   = CW'(n_q - k_val + WIDTH'(1));
                    state_d = CALC;
                end
            end
            CALC: begin
                t0_d  = fold(step);
                t1_d  = t0_q;
                t2_d  = t1_q;
                cnt_d = cnt_q - CW'(1);
                if (arith_ovf_en && (step[WIDTH+1:WIDTH] != 2'b00)) overflow_d = 1'b1;
                if (cnt_q == CW'(1)) begin
                    result_d = fold(step);
                    state_d  = FINISH;
                end
            end
            FINISH: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mode_q     <= MODE_FIB;
            n_q        <= '0;
            t0_q       <= '0;
            t1_q       <= '0;
            t2_q       <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
`ifdef PLUGIN_REC_MODULO_EN
            mod_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            n_q        <= n_d;
            t0_q       <= t0_d;
            t1_q       <= t1_d;
            t2_q       <= t2_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
`ifdef PLUGIN_REC_MODULO_EN
            mod_q      <= mod_d;
`endif
        end
    end

    assign bus.busy     = (state_q == LOAD) || (state_q == CALC);
    assign bus.done     = (state_q == FINISH);
    assign bus.result   = result_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_plugin_recurrence_gen.sv
// Directed bench for plugin_recurrence_gen: latency, results, overflow and abort behaviour.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_plugin_recurrence_gen;
    localparam int WIDTH = 32;
    localparam int MAX_N = 1023;
    localparam int BUDGET = 2000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    plugin_recurrence_gen_if #(.WIDTH(WIDTH)) bus ();

    plugin_recurrence_gen #(.WIDTH(WIDTH), .MAX_N(MAX_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Issues one request and waits for done. latency counts rising edges after the
    // accepting edge E0 up to the one that raised done (-1 if the budget ran out).
    // A nonzero inject_at pulses a competing start (Lucas, n=3) at that wait cycle.
    task automatic run_op(input logic [1:0] mode, input logic [WIDTH-1:0] n,
                          input logic [WIDTH-1:0] m, input int inject_at,
                          output int latency, output int busy_cycles);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.mode      = mode;
        bus.operand_a = n;
        bus.operand_b = m;
        @(posedge clk);
        @(negedge clk);
        bus.start   = 1'b0;
        latency     = -1;
        busy_cycles = bus.busy ? 1 : 0;
        for (int i = 1; i <= BUDGET; i++) begin
            if (i == inject_at) begin
                bus.start     = 1'b1;
                bus.mode      = 2'd1;
                bus.operand_a = 3;
            end
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) begin
                latency = i;
                break;
            end
            if (bus.busy) busy_cycles++;
        end
    endtask

    task automatic expect_op(input string name, input logic [1:0] mode, input logic [WIDTH-1:0] n,
                             input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] exp_result,
                             input logic exp_ovf, input int exp_latency);
        int lat;
        int bc;
        run_op(mode, n, m, 0, lat, bc);
        n_checks++;
        if (lat !== exp_latency) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_latency);
        end
        n_checks++;
        if (bus.result !== exp_result) begin
            n_fail++;
            $display("FAIL %s result: got %0d expected %0d", name, bus.result, exp_result);
        end
        n_checks++;
        if (bus.overflow !== exp_ovf) begin
            n_fail++;
            $display("FAIL %s overflow: got %0b expected %0b", name, bus.overflow, exp_ovf);
        end
    endtask

    task automatic test_reset();
        bus.start     = 1'b0;
        bus.mode      = 2'd0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        reset         = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({bus.busy, bus.done, bus.overflow} !== 3'b000 || bus.result !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%0b done=%0b ovf=%0b result=%0d expected all zero",
                     bus.busy, bus.done, bus.overflow, bus.result);
        end
    endtask

    task automatic test_fibonacci();
        int lat;
        int bc;
        run_op(2'd0, 10, 0, 0, lat, bc);
        n_checks++;
        if (lat !== 10 || bc !== 10) begin
            n_fail++;
            $display("FAIL fib10_timing: latency %0d busy %0d expected 10 and 10", lat, bc);
        end
        n_checks++;
        if (bus.result !== 55 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fib10_value: result %0d ovf %0b expected 55 and 0", bus.result, bus.overflow);
        end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: done %0b busy %0b expected 0 and 0 after FINISH", bus.done, bus.busy);
        end
        expect_op("fib1", 2'd0, 1, 0, 1, 1'b0, 1);
    endtask

    task automatic test_modes();
        expect_op("lucas0", 2'd1, 0, 0, 2, 1'b0, 1);
        expect_op("lucas5", 2'd1, 5, 0, 11, 1'b0, 5);
        expect_op("pell5", 2'd2, 5, 0, 29, 1'b0, 5);
        expect_op("trib4", 2'd3, 4, 0, 2, 1'b0, 3);
        expect_op("trib2", 2'd3, 2, 0, 1, 1'b0, 1);
    endtask

    task automatic test_back_to_back_overflow();
        expect_op("fib47", 2'd0, 47, 0, 32'd2971215073, 1'b0, 47);
        expect_op("fib48", 2'd0, 48, 0, 32'd512559680, 1'b1, 48);
        expect_op("fib5_after_ovf", 2'd0, 5, 0, 5, 1'b0, 5);
    endtask

    task automatic test_out_of_range();
        expect_op("fib_max_plus1", 2'd0, MAX_N + 1, 0, 0, 1'b1, 1);
        expect_op("fib_at_max_n_tail", 2'd0, 2, 0, 1, 1'b0, 2);
    endtask

    task automatic test_start_ignored();
        int lat;
        int bc;
        run_op(2'd0, 10, 0, 4, lat, bc);
        n_checks++;
        if (lat !== 10 || bus.result !== 55) begin
            n_fail++;
            $display("FAIL start_in_calc: latency %0d result %0d expected 10 and 55", lat, bus.result);
        end
        bus.start     = 1'b1;
        bus.operand_a = 3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_finish: busy %0b expected 0", bus.busy);
        end
    endtask

    task automatic test_reset_abort();
        int saw_done;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.mode      = 2'd0;
        bus.operand_a = 20;
        bus.operand_b = 0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort_state: busy %0b done %0b result %0d ovf %0b expected zeros",
                     bus.busy, bus.done, bus.result, bus.overflow);
        end
        saw_done = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.done) saw_done++;
        end
        n_checks++;
        if (saw_done !== 0) begin
            n_fail++;
            $display("FAIL reset_abort_no_done: %0d done pulses expected 0", saw_done);
        end
        expect_op("fib6_after_abort", 2'd0, 6, 0, 8, 1'b0, 6);
    endtask

`ifdef PLUGIN_REC_MODULO_EN
    task automatic test_modulo();
        expect_op("mod_fib10_m7", 2'd0, 10, 7, 6, 1'b0, 10);
        expect_op("mod_lucas0_m2", 2'd1, 0, 2, 0, 1'b0, 1);
        expect_op("mod_fib48_m1000", 2'd0, 48, 1000, 976, 1'b0, 48);
        expect_op("mod_pell5_m1", 2'd2, 5, 1, 0, 1'b0, 5);
    endtask
`endif

    initial begin
        test_reset();
        test_fibonacci();
        test_modes();
        test_back_to_back_overflow();
        test_out_of_range();
        test_start_ignored();
        test_reset_abort();
`ifdef PLUGIN_REC_MODULO_EN
        test_modulo();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/plugin_recurrence_gen.md
Name: plugin_recurrence_gen

Overview:
- Parametrised successor to the single-mode Fibonacci plugin accelerator.
- Computes the n-th term of one of four integer linear recurrences (Fibonacci, Lucas, Pell, Tribonacci) at configurable data width.
- Uses an iterative FSM, a sticky overflow flag and an out-of-range guard.
- Sits in the RS5 plugin slot behind the same start/busy/done handshake as the existing plugins.

Parameters:
- WIDTH, 32: data width of operands, internal term registers and result.
- MAX_N, 1023: largest accepted index; larger n is rejected.

Ports:
- clk  in  1  clock; all flops rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- mode  in  2  0=Fibonacci, 1=Lucas, 2=Pell, 3=Tribonacci; latched at start.
- operand_a  in  WIDTH  index n; latched at start.
- operand_b  in  WIDTH  modulus; used only with PLUGIN_REC_MODULO_EN, otherwise ignored.
- busy  out  1  high in LOAD and CALC.
- done  out  1  one-cycle pulse in FINISH.
- result  out  WIDTH  n-th term; held until the next accepted start.
- overflow  out  1  sticky per operation; valid with done, held with result.

Behaviour:
- Reset is synchronous, active-high, with one clock (clk) and a single reset input (reset). On reset: state=IDLE, busy=0, done=0, result=0, overflow=0, and all internal registers are cleared. Reset mid-operation aborts silently with no done pulse.
- Seeds and order k by mode:
  - Fibonacci: (0,1), k=2.
  - Lucas: (2,1), k=2.
  - Pell: (0,1), k=2, step = 2*a(n-1) + a(n-2).
  - Tribonacci: (0,0,1), k=3, step = sum of the last three terms.
- Iteration count: iters = n-(k-1) if n>=k, else 0.
- FSM transitions:
  - IDLE: on start, capture n, mode and modulus, clear overflow, go to LOAD. start is ignored in every other state, with no queueing.
  - LOAD (1 cycle): load seeds.
    - If n>MAX_N: result=0, overflow=1, go to FINISH.
    - Else if iters==0: result=seed[n], go to FINISH.
    - Else: counter=iters, go to CALC.
  - CALC (exactly iters cycles): each cycle shift the term window in, the new term becomes the current term, and counter decrements. When counter reaches 1, write the new term to result and go to FINISH.
  - FINISH (1 cycle): done=1, busy=0, then go to IDLE. A start seen during FINISH is ignored.
- Latency: start sampled at edge E0 gives done=1 in the cycle after edge E(1+iters). Back-to-back requests are possible when the next start is sampled in the first IDLE cycle after FINISH.
- Arithmetic:
  - Each step is computed at WIDTH+2 bits.
  - Stored terms are truncated to WIDTH.
  - Any nonzero bit above WIDTH in any step sets overflow, which stays set until the next start.
- busy and done are decoded from registered state only, never combinationally from inputs.
- result and overflow change only in LOAD or CALC cycles, or on reset.

Optional Feature:
- Macro: PLUGIN_REC_MODULO_EN.
- When defined, with modulus m = operand_b latched at start:
  - If m!=0, seeds are reduced mod m. Every step result is reduced by up to two conditional subtractions of m, valid because each step is below 3m.
  - overflow is never set by arithmetic when m!=0; the n>MAX_N rejection still sets it.
  - m==0 means no reduction, i.e. the plain behaviour.
  - m==1 yields result 0.
- When undefined: operand_b is unused, no modulus register or subtractors are built, and behaviour is as described in Behaviour.

Test Plan:
- Fibonacci, n=10: start at E0 -> busy high for 10 cycles, done after E10, result=55, overflow=0. Fibonacci n=1 -> result=1, done after E1.
- Lucas, n=0 -> result=2, iters=0, done after E1. Pell, n=5 -> result=29. Tribonacci, n=4 -> result=2, done after E3.
- WIDTH=32, Fibonacci n=47 -> 2971215073, overflow=0. Fibonacci n=48 -> result=512559680, overflow=1. The following n=5 request -> result=5, overflow=0.
- Fibonacci n=MAX_N+1 -> result=0, overflow=1, done after E1. start pulsed during CALC with n=3 -> ignored; the original result completes unchanged.
- Assert reset during CALC of Fibonacci n=20 -> next cycle IDLE, busy=0, result=0, no done pulse. A fresh n=6 request -> result=8.
- With PLUGIN_REC_MODULO_EN:
  - Fibonacci n=10, operand_b=7 -> result=6.
  - Lucas n=0, operand_b=2 -> result=0.
  - Fibonacci n=48, operand_b=1000 -> result=976, overflow=0.
